// File: rtl/riscv_controle_pkg.sv
`default_nettype none
//==============================================================================
// Package  : riscv_controle_pkg
// Brief    : Opcodes, state encoding and Moore output table of the multi-cycle
//            control unit. CONTROLE_JAL_EN adds the SALTO state (JAL/JALR).
// Revision : 1.0
//==============================================================================
package riscv_controle_pkg;

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;

    localparam logic [1:0] c_ULAB_RS2    = 2'b00;
    localparam logic [1:0] c_ULAB_QUATRO = 2'b01;
    localparam logic [1:0] c_ULAB_IMED   = 2'b10;

    localparam logic [1:0] c_ULAOP_SOMA  = 2'b00;
    localparam logic [1:0] c_ULAOP_SUB   = 2'b01;
    localparam logic [1:0] c_ULAOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        BUSCA       = 4'd0,
        DECODIFICA  = 4'd1,
        EXEC_R      = 4'd2,
        EXEC_I      = 4'd3,
        ESCRITA_ULA = 4'd4,
        CALC_END    = 4'd5,
        MEM_LE      = 4'd6,
        MEM_ESCREVE = 4'd7,
        ESCRITA_MEM = 4'd8,
        DESVIO      = 4'd9,
        ILEGAL      = 4'd10
`ifdef CONTROLE_JAL_EN
        ,
        SALTO       = 4'd11
`endif
    } estado_t;

    typedef struct packed {
        logic       escrevePC;
        logic       escreveReg;
        logic       leMem;
        logic       escreveMem;
        logic       desvio;
        logic       memParaReg;
        logic       iouD;
        logic       fonteA;
        logic [1:0] fonteB;
        logic [1:0] opULA;
        logic       erro;
`ifdef CONTROLE_JAL_EN
        logic       fonteReg;
`endif
    } saidas_t;

    function automatic estado_t decodifica(input logic [6:0] op);
        estado_t e;
        case (op)
            c_OP_R:      e = EXEC_R;
            c_OP_IMM:    e = EXEC_I;
            c_OP_LOAD:   e = CALC_END;
            c_OP_STORE:  e = CALC_END;
            c_OP_BRANCH: e = DESVIO;
`ifdef CONTROLE_JAL_EN
            c_OP_JAL:    e = SALTO;
            c_OP_JALR:   e = SALTO;
`endif
            default:     e = ILEGAL;
        endcase
        return e;
    endfunction

    // Moore outputs only; the fetch-time IR/PC write and the JALR operand
    // select depend on inputs and are resolved in the top.
    function automatic saidas_t saidasMoore(input estado_t e);
        saidas_t s;
        s = '0;
        case (e)
            BUSCA: begin
                s.leMem  = 1'b1;
                s.fonteB = c_ULAB_QUATRO;
            end
            DECODIFICA: s.fonteB = c_ULAB_IMED;
            EXEC_R: begin
                s.fonteA = 1'b1;
                s.fonteB = c_ULAB_RS2;
                s.opULA  = c_ULAOP_FUNCT;
            end
            EXEC_I: begin
                s.fonteA = 1'b1;
                s.fonteB = c_ULAB_IMED;
                s.opULA  = c_ULAOP_FUNCT;
            end
            ESCRITA_ULA: s.escreveReg = 1'b1;
            CALC_END: begin
                s.fonteA = 1'b1;
                s.fonteB = c_ULAB_IMED;
                s.opULA  = c_ULAOP_SOMA;
            end
            MEM_LE: begin
                s.leMem = 1'b1;
                s.iouD  = 1'b1;
            end
            MEM_ESCREVE: begin
                s.escreveMem = 1'b1;
                s.iouD       = 1'b1;
            end
            ESCRITA_MEM: begin
                s.escreveReg = 1'b1;
                s.memParaReg = 1'b1;
            end
            DESVIO: begin
                s.fonteA = 1'b1;
                s.fonteB = c_ULAB_RS2;
                s.opULA  = c_ULAOP_SUB;
                s.desvio = 1'b1;
            end
            ILEGAL: s.erro = 1'b1;
`ifdef CONTROLE_JAL_EN
            SALTO: begin
                s.escreveReg = 1'b1;
                s.escrevePC  = 1'b1;
                s.fonteB     = c_ULAB_IMED;
                s.opULA      = c_ULAOP_SOMA;
                s.fonteReg   = 1'b1;
            end
`endif
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/contador_timeout.sv
`default_nettype none
//==============================================================================
// Module   : contador_timeout
// Brief    : Wait-cycle counter; expirou flags the last allowed wait cycle.
// Revision : 1.0
//==============================================================================
module contador_timeout #(
    parameter int TIMEOUT_CICLOS = 16
) (
    input  logic clk,
    input  logic limpa,
    input  logic habilita,
    output logic expirou
);

    localparam int               c_W      = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [c_W-1:0]   c_LIMITE = c_W'(TIMEOUT_CICLOS - 1);

    logic [c_W-1:0] r_conta;

    always_ff @(posedge clk) begin
        if (limpa) begin
            r_conta <= '0;
        end else if (habilita && !expirou) begin
            r_conta <= r_conta + 1'b1;
        end
    end

    // Count equals cycles already spent waiting, so this is the Nth wait cycle.
    assign expirou = (r_conta >= c_LIMITE);

endmodule
`default_nettype wire

// File: rtl/controle_multiciclo.sv
`default_nettype none
//==============================================================================
// Module   : controle_multiciclo
// Brief    : Multi-cycle RISC-V control FSM with memory handshake and timeout.
//            CONTROLE_JAL_EN enables JAL/JALR (SALTO state, FonteReg output).
// Revision : 1.0
//==============================================================================
module controle_multiciclo
    import riscv_controle_pkg::*;
#(
    parameter int OPCODE_W       = 7,
    parameter int ULAOP_W        = 2,
    parameter int TIMEOUT_CICLOS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] CodigoDaOperacao,
    input  logic                MemPronto,
    output logic                EscrevePC,
    output logic                EscreveIR,
    output logic                EscreveRegistrador,
    output logic                LeMemoria,
    output logic                EscreveMemoria,
    output logic                Desvio,
    output logic                MemParaReg,
    output logic                IouD,
    output logic                FonteULA_A,
    output logic [1:0]          FonteULA_B,
    output logic [ULAOP_W-1:0]  OperacaoULA,
    output logic                Erro,
`ifdef CONTROLE_JAL_EN
    output logic                FonteReg,
`endif
    output logic [3:0]          Estado
);

    estado_t  r_estado;
    estado_t  w_prox;
    saidas_t  r_saidas;
    saidas_t  w_moore;
    saidas_t  w_s;
    logic     w_espera;
    logic     w_limpa;
    logic     w_expirou;
    logic     w_buscaPronta;
    logic [6:0] w_opcode;

    assign w_opcode = 7'(CodigoDaOperacao);
    assign w_espera = (r_estado == BUSCA) || (r_estado == MEM_LE) || (r_estado == MEM_ESCREVE);
    assign w_limpa  = !rst_n || (w_prox != r_estado);

    contador_timeout #(
        .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
    ) u_contador (
        .clk     (clk),
        .limpa   (w_limpa),
        .habilita(w_espera),
        .expirou (w_expirou)
    );

    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            BUSCA: begin
                if (MemPronto)      w_prox = DECODIFICA;
                else if (w_expirou) w_prox = ILEGAL;
            end
            DECODIFICA:  w_prox = decodifica(w_opcode);
            EXEC_R:      w_prox = ESCRITA_ULA;
            EXEC_I:      w_prox = ESCRITA_ULA;
            CALC_END:    w_prox = (w_opcode == c_OP_LOAD) ? MEM_LE : MEM_ESCREVE;
            MEM_LE: begin
                if (MemPronto)      w_prox = ESCRITA_MEM;
                else if (w_expirou) w_prox = ILEGAL;
            end
            MEM_ESCREVE: begin
                if (MemPronto)      w_prox = BUSCA;
                else if (w_expirou) w_prox = ILEGAL;
            end
            default:     w_prox = BUSCA;
        endcase
    end

    // Outputs are registered from the next state, so they line up with r_estado.
    always_comb begin
        w_moore = saidasMoore(w_prox);
`ifdef CONTROLE_JAL_EN
        if (w_prox == SALTO) begin
            w_moore.fonteA = (w_opcode == c_OP_JALR);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_estado <= BUSCA;
            r_saidas <= saidasMoore(BUSCA);
        end else begin
            r_estado <= w_prox;
            r_saidas <= w_moore;
        end
    end

    // Reset holds the datapath at fetch operand selects with every strobe off.
    always_comb begin
        w_s = r_saidas;
        if (!rst_n) begin
            w_s        = '0;
            w_s.fonteB = c_ULAB_QUATRO;
        end
    end

    assign w_buscaPronta      = rst_n && (r_estado == BUSCA) && MemPronto;

    assign EscrevePC          = w_s.escrevePC | w_buscaPronta;
    assign EscreveIR          = w_buscaPronta;
    assign EscreveRegistrador = w_s.escreveReg;
    assign LeMemoria          = w_s.leMem;
    assign EscreveMemoria     = w_s.escreveMem;
    assign Desvio             = w_s.desvio;
    assign MemParaReg         = w_s.memParaReg;
    assign IouD               = w_s.iouD;
    assign FonteULA_A         = w_s.fonteA;
    assign FonteULA_B         = w_s.fonteB;
    assign OperacaoULA        = ULAOP_W'(w_s.opULA);
    assign Erro               = w_s.erro;
`ifdef CONTROLE_JAL_EN
    assign FonteReg           = w_s.fonteReg;
`endif
    assign Estado             = rst_n ? r_estado : BUSCA;

endmodule
`default_nettype wire

// File: tb/tb_controle_multiciclo.sv
`default_nettype none
//==============================================================================
// Module   : tb_controle_multiciclo
// Brief    : Self-checking bench: instruction-level reference plan vs. DUT.
//            Follows CONTROLE_JAL_EN when defined.
// Revision : 1.0
//==============================================================================
module tb_controle_multiciclo;
    import riscv_controle_pkg::*;

    localparam int c_TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] CodigoDaOperacao;
    logic       MemPronto;
    logic       EscrevePC, EscreveIR, EscreveRegistrador, LeMemoria, EscreveMemoria;
    logic       Desvio, MemParaReg, IouD, FonteULA_A, Erro;
    logic [1:0] FonteULA_B;
    logic [1:0] OperacaoULA;
    logic [3:0] Estado;
    logic       w_fonteReg;

    controle_multiciclo #(
        .OPCODE_W(7), .ULAOP_W(2), .TIMEOUT_CICLOS(c_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .CodigoDaOperacao(CodigoDaOperacao), .MemPronto(MemPronto),
        .EscrevePC(EscrevePC), .EscreveIR(EscreveIR), .EscreveRegistrador(EscreveRegistrador),
        .LeMemoria(LeMemoria), .EscreveMemoria(EscreveMemoria), .Desvio(Desvio),
        .MemParaReg(MemParaReg), .IouD(IouD), .FonteULA_A(FonteULA_A), .FonteULA_B(FonteULA_B),
        .OperacaoULA(OperacaoULA), .Erro(Erro),
`ifdef CONTROLE_JAL_EN
        .FonteReg(w_fonteReg),
`endif
        .Estado(Estado)
    );
`ifndef CONTROLE_JAL_EN
    assign w_fonteReg = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct packed {
        logic        mp;
        logic [6:0]  op;
        logic [15:0] esp;
        logic [3:0]  estado;
    } ciclo_t;

    ciclo_t plano[$];
    int nChecks = 0;
    int nErros  = 0;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        nChecks++;
        if (obs !== esp) begin
            nErros++;
            $display("FAIL %s: obtido=%h esperado=%h (t=%0t)", tag, obs, esp, $time);
        end
    endtask

    function automatic logic [15:0] vet(input logic epc, eir, ereg, le, em, desv, m2r, iou, a,
                                        input logic [1:0] b, op, input logic erro, freg);
        return {1'b0, epc, eir, ereg, le, em, desv, m2r, iou, a, b, op, erro, freg};
    endfunction

    function automatic logic [15:0] observado();
        return {1'b0, EscrevePC, EscreveIR, EscreveRegistrador, LeMemoria, EscreveMemoria, Desvio,
                MemParaReg, IouD, FonteULA_A, FonteULA_B, OperacaoULA, Erro, w_fonteReg};
    endfunction

    // Expected outputs per phase, straight from the control table.
    localparam logic [15:0] V_RESET   = 16'b0_000000000_01_00_0_0;
    localparam logic [15:0] V_BUSCA0  = 16'b0_000100000_01_00_0_0;
    localparam logic [15:0] V_BUSCA1  = 16'b0_110100000_01_00_0_0;
    localparam logic [15:0] V_DEC     = 16'b0_000000000_10_00_0_0;
    localparam logic [15:0] V_EXECR   = 16'b0_000000001_00_10_0_0;
    localparam logic [15:0] V_EXECI   = 16'b0_000000001_10_10_0_0;
    localparam logic [15:0] V_ESCULA  = 16'b0_001000000_00_00_0_0;
    localparam logic [15:0] V_CALC    = 16'b0_000000001_10_00_0_0;
    localparam logic [15:0] V_MEMLE   = 16'b0_000100010_00_00_0_0;
    localparam logic [15:0] V_MEMESC  = 16'b0_000010010_00_00_0_0;
    localparam logic [15:0] V_ESCMEM  = 16'b0_001000100_00_00_0_0;
    localparam logic [15:0] V_DESVIO  = 16'b0_000001001_00_01_0_0;
    localparam logic [15:0] V_ILEGAL  = 16'b0_000000000_00_00_1_0;

    task automatic poe(input logic mp, input logic [6:0] op, input logic [15:0] esp, input estado_t e);
        ciclo_t c;
        c.mp = mp; c.op = op; c.esp = esp; c.estado = 4'(e);
        plano.push_back(c);
    endtask

    task automatic fase(input estado_t e, input logic [15:0] esp);
        poe(1'($urandom), 7'($urandom), esp, e);
    endtask

    task automatic espera(input estado_t e, input int n, input logic [15:0] vParado,
                          input logic [15:0] vPronto, output bit expirou);
        if (n >= c_TIMEOUT) begin
            repeat (c_TIMEOUT) poe(1'b0, 7'($urandom), vParado, e);
            fase(ILEGAL, V_ILEGAL);
            expirou = 1'b1;
        end else begin
            repeat (n) poe(1'b0, 7'($urandom), vParado, e);
            poe(1'b1, 7'($urandom), vPronto, e);
            expirou = 1'b0;
        end
    endtask

    // Reference: expand one instruction into its expected cycle sequence.
    task automatic instrucao(input logic [6:0] op, input int esperaBusca, input int esperaMem);
        bit exp;
        espera(BUSCA, esperaBusca, V_BUSCA0, V_BUSCA1, exp);
        if (exp) return;
        poe(1'($urandom), op, V_DEC, DECODIFICA);
        case (op)
            c_OP_R:      begin fase(EXEC_R, V_EXECR); fase(ESCRITA_ULA, V_ESCULA); end
            c_OP_IMM:    begin fase(EXEC_I, V_EXECI); fase(ESCRITA_ULA, V_ESCULA); end
            c_OP_LOAD: begin
                poe(1'($urandom), op, V_CALC, CALC_END);
                espera(MEM_LE, esperaMem, V_MEMLE, V_MEMLE, exp);
                if (!exp) fase(ESCRITA_MEM, V_ESCMEM);
            end
            c_OP_STORE: begin
                poe(1'($urandom), op, V_CALC, CALC_END);
                espera(MEM_ESCREVE, esperaMem, V_MEMESC, V_MEMESC, exp);
            end
            c_OP_BRANCH: fase(DESVIO, V_DESVIO);
`ifdef CONTROLE_JAL_EN
            c_OP_JAL:    fase(SALTO, vet(1,0,1,0,0,0,0,0,0,2'b10,2'b00,0,1));
            c_OP_JALR:   fase(SALTO, vet(1,0,1,0,0,0,0,0,1,2'b10,2'b00,0,1));
`endif
            default:     fase(ILEGAL, V_ILEGAL);
        endcase
    endtask

    task automatic executa();
        ciclo_t c;
        while (plano.size() > 0) begin
            c = plano.pop_front();
            @(negedge clk);
            rst_n            = 1'b1;
            MemPronto        = c.mp;
            CodigoDaOperacao = c.op;
            #2;
            verifica("saidas", 32'(observado()), 32'(c.esp));
            verifica("estado", 32'(Estado), 32'(c.estado));
        end
    endtask

    task automatic pulsoReset(input int n);
        repeat (n) begin
            @(negedge clk);
            rst_n            = 1'b0;
            MemPronto        = 1'b1;
            CodigoDaOperacao = 7'($urandom);
            #2;
            verifica("reset_saidas", 32'(observado()), 32'(V_RESET));
            verifica("reset_estado", 32'(Estado), 32'(BUSCA));
        end
    endtask

    function automatic int esperaAleat();
        return ($urandom_range(0, 11) == 0) ? c_TIMEOUT : int'($urandom_range(0, 3));
    endfunction

    initial begin
        bit exp;
        logic [6:0] op;
        rst_n = 1'b0; MemPronto = 1'b0; CodigoDaOperacao = '0;
        pulsoReset(2);

        instrucao(c_OP_R, 0, 0);        // 4 cycles
        instrucao(c_OP_LOAD, 0, 3);     // 8 cycles
        instrucao(c_OP_STORE, 0, 16);   // memory timeout
        instrucao(7'b1111111, 0, 0);    // illegal opcode
        instrucao(c_OP_JAL, 0, 0);
        instrucao(c_OP_JALR, 1, 0);
        instrucao(c_OP_BRANCH, 2, 0);
        instrucao(c_OP_IMM, 0, 0);
        executa();

        // Abort in MEM_ESCREVE, then prove the wait counter restarted from 0.
        espera(BUSCA, 0, V_BUSCA0, V_BUSCA1, exp);
        poe(1'b0, c_OP_STORE, V_DEC, DECODIFICA);
        poe(1'b1, c_OP_STORE, V_CALC, CALC_END);
        poe(1'b0, 7'($urandom), V_MEMESC, MEM_ESCREVE);
        poe(1'b0, 7'($urandom), V_MEMESC, MEM_ESCREVE);
        executa();
        pulsoReset(1);
        instrucao(c_OP_R, c_TIMEOUT, 0);
        instrucao(c_OP_R, c_TIMEOUT - 1, 0);
        executa();

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 7))
                0: op = c_OP_R;
                1: op = c_OP_IMM;
                2: op = c_OP_LOAD;
                3: op = c_OP_STORE;
                4: op = c_OP_BRANCH;
                5: op = c_OP_JAL;
                6: op = c_OP_JALR;
                default: op = 7'($urandom);
            endcase
            instrucao(op, esperaAleat(), esperaAleat());
            executa();
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErros);
        $finish;
    end

endmodule
`default_nettype wire
